video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Source end of the pixel-stream interface that the overlay/annotation stage consumes. It produces the per-pixel x/y coordinates, HSync, VSync and VDE.
- Optionally produces a colour-bar test image on RGB_Data for bring-up without a camera.
- Sits upstream of the overlay block and replaces the camera/decoder timing during board bring-up and simulation.
- Default timing is 1280x720p60 (74.25 MHz pixel clock).

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, HSync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, VSync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, sampled at frame boundaries only
- RGB_x  out  11  horizontal counter, 0..H_TOTAL-1
- RGB_y  out  10  vertical counter, 0..V_TOTAL-1
- RGB_HSync  out  1  horizontal sync, polarity set by SYNC_POL
- RGB_VSync  out  1  vertical sync, polarity set by SYNC_POL
- RGB_VDE  out  1  active-video flag
- RGB_Data  out  24  pixel data, [23:16]=R, [15:8]=G, [7:0]=B
- frame_start  out  1  one-cycle pulse coincident with x=0, y=0
- busy  out  1  high while in RUN

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-low (rst_n).
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Line order is active, front porch, sync, back porch. Frame order follows the same sequence in lines.
- Reset values:
  - state IDLE, counters 0
  - RGB_x=0, RGB_y=0
  - HSync and VSync at inactive level (~SYNC_POL)
  - VDE=0, RGB_Data=0, frame_start=0, busy=0
- All outputs are registered and mutually aligned: every output in a given cycle describes the same pixel.
- State machine:
  - IDLE: counters held at 0, syncs inactive, VDE=0. If en=1, go to RUN. The first RUN cycle outputs x=0, y=0, frame_start=1, busy=1.
  - RUN: x increments every cycle. At x=H_TOTAL-1, x wraps to 0 and y increments. At x=H_TOTAL-1 and y=V_TOTAL-1 (last pixel of the frame):
    - en=1: wrap to 0,0 and pulse frame_start.
    - en=0: go to IDLE. The next cycle shows the IDLE output values.
  - en changes mid-frame are ignored. A frame is never truncated.
- HSync is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (x=1390..1429 by default), on every line.
- VSync is active for whole lines V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (y=725..729). It asserts at x=0 of line 725 and releases at x=0 of line 730.
- VDE = (x < H_ACTIVE) && (y < V_ACTIVE).
- RGB_x and RGB_y carry the raw counter values during blanking as well.
  - Downstream comparisons against box edges are valid only while VDE=1.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). Restart requires en high after rst_n releases.
- Elaboration check: H_TOTAL <= 2048, V_TOTAL <= 1024, H_ACTIVE divisible by 8. A violation is an $error.

Optional Feature:
- Macro: VIDEO_TIMING_COLORBAR_EN.
- Defined:
  - RGB_Data shows 8 vertical bars, each H_ACTIVE/8 wide (160 pixels), in this order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - No divider is used. A bar sub-counter advances the bar index every H_ACTIVE/8 active pixels and clears at x=0.
  - RGB_Data = 0 whenever VDE=0.
- Undefined: RGB_Data is constant 0 and no bar logic is synthesised. Timing outputs are identical in both builds.

Decomposition:
- Shared package video_pkg holds:
  - 720p timing default constants
  - X_W=11 and Y_W=10 coordinate widths
  - 24-bit colour constants (the bar colours plus the overlay border colours)
  - the 8-entry bar colour table
- Sub-module colorbar_gen (x counter and VDE in, RGB_Data out, one-register stage) is compiled under the macro. The timing path is delayed to match its latency.

Test Plan:
- Reset, then en=1 -> first RUN cycle shows x=0, y=0, frame_start=1, VDE=1. frame_start pulses again exactly 1,237,500 cycles later.
- Line check -> HSync active for exactly 40 cycles per line at x=1390..1429. VDE high for 1280 cycles per active line and 0 on lines 720..749.
- Frame check -> VSync active for lines 725..729 only (5×1650 cycles), edges at x=0. SYNC_POL=0 build shows inverted syncs.
- Drop en at y=100 -> frame completes to x=1649, y=749, then IDLE (busy=0, x=y=0, VDE=0, no frame_start). Raise en -> restart at 0,0.
- rst_n low at x=500, y=300 -> all outputs take reset values in the same cycle, with no clk edge needed.
- VIDEO_TIMING_COLORBAR_EN defined -> line 0 shows x=0..159 FFFFFF, x=160 FFFF00, x=1120..1279 000000, and RGB_Data=0 at x=1280.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants: coordinate widths, 720p60 timing defaults, colour palette
// and the colour-bar lookup table.
package video_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned BAR_N = 8;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] COL_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;

  // Overlay stage box borders
  localparam logic [RGB_W-1:0] COL_BORDER_ROI = COL_GREEN;
  localparam logic [RGB_W-1:0] COL_BORDER_SEL = COL_RED;

  // Index 0 is the leftmost bar (white)
  localparam logic [BAR_N-1:0][RGB_W-1:0] BAR_TABLE = {
    COL_BLACK, COL_BLUE, COL_RED, COL_MAGENTA,
    COL_GREEN, COL_CYAN, COL_YELLOW, COL_WHITE
  };

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-stream bundle between the timing source and the overlay stage.
interface video_timing_if;
  import video_pkg::*;

  logic [X_W-1:0]   RGB_x;
  logic [Y_W-1:0]   RGB_y;
  logic             RGB_HSync;
  logic             RGB_VSync;
  logic             RGB_VDE;
  logic [RGB_W-1:0] RGB_Data;
  logic             frame_start;
  logic             busy;

  modport master (output RGB_x, RGB_y, RGB_HSync, RGB_VSync, RGB_VDE, RGB_Data,
                  frame_start, busy);
  modport slave  (input  RGB_x, RGB_y, RGB_HSync, RGB_VSync, RGB_VDE, RGB_Data,
                  frame_start, busy);
endinterface

// File: rtl/video_timing_gen_colorbar.sv
// Eight-bar test pattern; one register stage from (x, vde) to RGB data.
// Bar index is tracked with a sub-counter so no divider is needed.
module colorbar_gen
  import video_pkg::*;
#(
  parameter int unsigned BAR_W = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [X_W-1:0]   i_x,
  input  logic             i_vde,
  output logic [RGB_W-1:0] o_rgb
);

  localparam logic [X_W-1:0] SUB_LAST = X_W'(BAR_W - 1);

  logic [X_W-1:0] r_sub;
  logic [X_W-1:0] w_sub;
  logic [2:0]     r_bar;
  logic [2:0]     w_bar;

  // Position within the current bar, forced back to bar 0 at the start of each line
  always_comb begin
    w_sub = r_sub;
    w_bar = r_bar;
    if (i_x == '0) begin
      w_sub = '0;
      w_bar = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= '0;
      r_bar <= '0;
      o_rgb <= '0;
    end else begin
      o_rgb <= i_vde ? bar_color(w_bar) : '0;
      if (i_vde && (w_sub == SUB_LAST)) begin
        r_sub <= '0;
        r_bar <= w_bar + 3'd1;
      end else if (i_vde) begin
        r_sub <= w_sub + X_W'(1);
        r_bar <= w_bar;
      end else begin
        r_sub <= w_sub;
        r_bar <= w_bar;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing source: x/y counters, syncs, VDE and frame_start for the overlay stage.
// Define VIDEO_TIMING_COLORBAR_EN to add the colour-bar pattern on RGB_Data (+1 cycle latency).
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  video_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] X_HS0  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] X_HS1  = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_VS0  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] Y_VS1  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = !SYNC_POL;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (H_TOTAL > (2 ** X_W)) begin : g_bad_htotal
    $error("video_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, 2 ** X_W);
  end
  if (V_TOTAL > (2 ** Y_W)) begin : g_bad_vtotal
    $error("video_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, 2 ** Y_W);
  end
  if ((H_ACTIVE % 8) != 0) begin : g_bad_hactive
    $error("video_timing_gen: H_ACTIVE %0d not divisible by 8", H_ACTIVE);
  end

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [X_W-1:0] r_x;
  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] r_y;
  logic [Y_W-1:0] w_y_nxt;
  logic           w_run_nxt;
  logic           r_hs, r_vs, r_vde, r_fs, r_busy;
  logic           w_hs_nxt, w_vs_nxt, w_vde_nxt, w_fs_nxt;

  // Next pixel position; all outputs are decoded from it so they register together
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = '0;
    w_y_nxt     = '0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_x == X_LAST) begin
          if (r_y == Y_LAST) begin
            if (!en) w_state_nxt = ST_IDLE;
          end else begin
            w_y_nxt = r_y + Y_W'(1);
          end
        end else begin
          w_x_nxt = r_x + X_W'(1);
          w_y_nxt = r_y;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_run_nxt = (w_state_nxt == ST_RUN);
    w_hs_nxt  = (w_run_nxt && (w_x_nxt >= X_HS0) && (w_x_nxt < X_HS1)) ? SYNC_ON : SYNC_OFF;
    w_vs_nxt  = (w_run_nxt && (w_y_nxt >= Y_VS0) && (w_y_nxt < Y_VS1)) ? SYNC_ON : SYNC_OFF;
    w_vde_nxt = w_run_nxt && (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
    w_fs_nxt  = w_run_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= SYNC_OFF;
      r_vs    <= SYNC_OFF;
      r_vde   <= 1'b0;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_vde   <= w_vde_nxt;
      r_fs    <= w_fs_nxt;
      r_busy  <= w_run_nxt;
    end
  end

`ifdef VIDEO_TIMING_COLORBAR_EN
  logic [X_W-1:0]   r2_x;
  logic [Y_W-1:0]   r2_y;
  logic             r2_hs, r2_vs, r2_vde, r2_fs, r2_busy;
  logic [RGB_W-1:0] w_rgb;

  colorbar_gen #(
    .BAR_W (H_ACTIVE / 8)
  ) u_colorbar (
    .clk   (clk),
    .rst_n (rst_n),
    .i_x   (r_x),
    .i_vde (r_vde),
    .o_rgb (w_rgb)
  );

  // Timing delayed one stage to stay aligned with the pattern register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_x    <= '0;
      r2_y    <= '0;
      r2_hs   <= SYNC_OFF;
      r2_vs   <= SYNC_OFF;
      r2_vde  <= 1'b0;
      r2_fs   <= 1'b0;
      r2_busy <= 1'b0;
    end else begin
      r2_x    <= r_x;
      r2_y    <= r_y;
      r2_hs   <= r_hs;
      r2_vs   <= r_vs;
      r2_vde  <= r_vde;
      r2_fs   <= r_fs;
      r2_busy <= r_busy;
    end
  end

  assign vid.RGB_x       = r2_x;
  assign vid.RGB_y       = r2_y;
  assign vid.RGB_HSync   = r2_hs;
  assign vid.RGB_VSync   = r2_vs;
  assign vid.RGB_VDE     = r2_vde;
  assign vid.RGB_Data    = w_rgb;
  assign vid.frame_start = r2_fs;
  assign vid.busy        = r2_busy;
`else
  assign vid.RGB_x       = r_x;
  assign vid.RGB_y       = r_y;
  assign vid.RGB_HSync   = r_hs;
  assign vid.RGB_VSync   = r_vs;
  assign vid.RGB_VDE     = r_vde;
  assign vid.RGB_Data    = '0;
  assign vid.frame_start = r_fs;
  assign vid.busy        = r_busy;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster; reference model tracks a linear
// pixel index per frame and derives every output from it arithmetically.
module tb_video_timing_gen;

  localparam int HA = 64, HFP = 6, HSW = 5, HBP = 9;
  localparam int VA = 12, VFP = 2, VSW = 3, VBP = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

`ifdef VIDEO_TIMING_COLORBAR_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif

  typedef struct {
    int          x;
    int          y;
    bit          hs;
    bit          vs;
    bit          vde;
    bit          fs;
    bit          busy;
    logic [23:0] rgb;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;

  video_timing_if vif0 ();
  video_timing_if vif1 ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_POL (1'b1)
  ) u_dut_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vid   (vif0)
  );

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SYNC_POL (1'b0)
  ) u_dut_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vid   (vif1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit m_run, m_run_d;
  int m_p, m_p_d;

  int hs_cnt, vde_cnt, vs_cnt, last_fs;
  bit fs_valid;

  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t model_out(input bit run, input int p, input bit pol);
    exp_t e;
    e.x    = run ? (p % HT) : 0;
    e.y    = run ? (p / HT) : 0;
    e.hs   = (run && e.x >= HA + HFP && e.x < HA + HFP + HSW) ? pol : !pol;
    e.vs   = (run && e.y >= VA + VFP && e.y < VA + VFP + VSW) ? pol : !pol;
    e.vde  = run && (e.x < HA) && (e.y < VA);
    e.fs   = run && (p == 0);
    e.busy = run;
    e.rgb  = (CB && e.vde) ? bar_rgb[e.x / (HA / 8)] : 24'h0;
    return e;
  endfunction

  task automatic model_reset();
    m_run = 0; m_p = 0; m_run_d = 0; m_p_d = 0;
    hs_cnt = 0; vde_cnt = 0; vs_cnt = 0; fs_valid = 0; last_fs = 0;
  endtask

  // One clock of the reference: idle waits for en, a frame always runs to its last pixel
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_run_d = m_run;
      m_p_d   = m_p;
      if (!m_run) begin
        if (en) begin m_run = 1; m_p = 0; end
      end else if (m_p == FRAME - 1) begin
        if (en) m_p = 0;
        else begin m_run = 0; m_p = 0; end
      end else begin
        m_p++;
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e0, e1;
    bit   r;
    int   p;
    r  = CB ? m_run_d : m_run;
    p  = CB ? m_p_d : m_p;
    e0 = model_out(r, p, 1'b1);
    e1 = model_out(r, p, 1'b0);
    check_eq("x",           64'(vif0.RGB_x),       64'(e0.x));
    check_eq("y",           64'(vif0.RGB_y),       64'(e0.y));
    check_eq("hsync",       64'(vif0.RGB_HSync),   64'(e0.hs));
    check_eq("vsync",       64'(vif0.RGB_VSync),   64'(e0.vs));
    check_eq("vde",         64'(vif0.RGB_VDE),     64'(e0.vde));
    check_eq("frame_start", 64'(vif0.frame_start), 64'(e0.fs));
    check_eq("busy",        64'(vif0.busy),        64'(e0.busy));
    check_eq("rgb",         64'(vif0.RGB_Data),    64'(e0.rgb));
    check_eq("x_neg",       64'(vif1.RGB_x),       64'(e1.x));
    check_eq("hsync_neg",   64'(vif1.RGB_HSync),   64'(e1.hs));
    check_eq("vsync_neg",   64'(vif1.RGB_VSync),   64'(e1.vs));
  endtask

  // Per-line and per-frame totals straight from the timing constants
  task automatic aggregates();
    if (vif0.busy) begin
      if (vif0.RGB_x == 0) begin hs_cnt = 0; vde_cnt = 0; end
      if (vif0.frame_start) begin
        if (fs_valid) check_eq("fs_interval", 64'(cyc - last_fs), 64'(FRAME));
        last_fs = cyc; fs_valid = 1; vs_cnt = 0;
      end
      hs_cnt  += int'(vif0.RGB_HSync);
      vde_cnt += int'(vif0.RGB_VDE);
      vs_cnt  += int'(vif0.RGB_VSync);
      if (int'(vif0.RGB_x) == HT - 1) begin
        check_eq("hs_per_line",  64'(hs_cnt),  64'(HSW));
        check_eq("vde_per_line", 64'(vde_cnt), 64'((int'(vif0.RGB_y) < VA) ? HA : 0));
        if (int'(vif0.RGB_y) == VT - 1) check_eq("vs_per_frame", 64'(vs_cnt), 64'(VSW * HT));
      end
    end else begin
      fs_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_outputs();
    aggregates();
  endtask

  // Called 1 time unit after a rising edge; reset lands between edges
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    #12;
    check_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    en = 1'b1;
    repeat (2 * FRAME + 5) tick();

    for (int i = 0; i < FRAME && int'(vif0.RGB_y) != 5; i++) tick();
    check_eq("reach_y5", 64'(vif0.RGB_y), 64'(5));
    en = 1'b0;
    for (int i = 0; i < FRAME + 2 && vif0.busy; i++) tick();
    check_eq("drop_to_idle", 64'(vif0.busy), 64'(0));
    repeat (5) tick();
    en = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 2 * FRAME && !(int'(vif0.RGB_x) == 30 && int'(vif0.RGB_y) == 7); i++) tick();
    check_eq("reach_x30_y7", 64'({vif0.RGB_y, vif0.RGB_x}), 64'({10'd7, 11'd30}));
    async_reset();
    repeat (FRAME / 2) tick();

    k = int'($urandom_range(2000, 5000));
    for (int i = 0; i < 8000; i++) begin
      tick();
      if ($urandom_range(0, 299) == 0) en = ~en;
      if (i == k) async_reset();
    end
    en = 1'b1;
    repeat (FRAME + 10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
